// File: rtl/cmd_pkg.sv
// Shared constants for the command conditioner: debounce default, counter
// sizing, command indices (lowest index = highest priority) and prog width.
package cmd_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int PROG_W                  = 3;
    localparam int NUM_CMD                 = 4;

    // Command indices, listed in descending arbitration priority.
    localparam int CMD_STOP    = 0;
    localparam int CMD_UPDATE  = 1;
    localparam int CMD_START_F = 2;
    localparam int CMD_START_T = 3;

    // Debounce counter width; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-FF synchronizer, stability counter and a
// registered rising-edge detector that emits a single-cycle press pulse.
module btn_debounce
    import cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchronizer, count while the synced input
    // disagrees with the accepted level, accept it once the count saturates.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        sync1_d  = btn;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                press_d  = sync2_q;  // only a 0->1 acceptance is an event
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State register; reset discards any partial count and synced history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so all flops sample pre-edge values together.
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/cmd_conditioner.sv
// Board front end: debounces four buttons, arbitrates simultaneous presses
// (stop > update > start_f > start_t) and registers one-cycle command pulses,
// with prog carrying the synced switch code only during the update pulse.
module cmd_conditioner
    import cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start_f,
    input  logic              btn_start_t,
    input  logic              btn_update,
    input  logic              btn_stop,
    input  logic [PROG_W-1:0] sw_prog,
    output logic              start_f,
    output logic              start_t,
    output logic              update,
    output logic              stop_f_t,
    output logic [PROG_W-1:0] prog
);

    logic [NUM_CMD-1:0] btn_raw;
    logic [NUM_CMD-1:0] press;
    logic [NUM_CMD-1:0] grant;
    logic [NUM_CMD-1:0] cmd_q, cmd_d;
    logic [PROG_W-1:0]  sw_sync1_q, sw_sync1_d;
    logic [PROG_W-1:0]  sw_sync2_q, sw_sync2_d;
    logic [PROG_W-1:0]  prog_q, prog_d;

    assign btn_raw[CMD_STOP]    = btn_stop;
    assign btn_raw[CMD_UPDATE]  = btn_update;
    assign btn_raw[CMD_START_F] = btn_start_f;
    assign btn_raw[CMD_START_T] = btn_start_t;

    for (genvar i = 0; i < NUM_CMD; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_raw[i]),
            .press(press[i])
        );
    end

    // Keep only the lowest-index (highest-priority) press; others are dropped.
    assign grant = press & (~press + NUM_CMD'(1));

    // Next-state for switch synchronizer and output registers.
    always_comb begin
        sw_sync1_d = sw_prog;
        sw_sync2_d = sw_sync1_q;
        cmd_d      = grant;
        prog_d     = grant[CMD_UPDATE] ? sw_sync2_q : '0;
    end

    // Output and switch-synchronizer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            cmd_q      <= '0;
            prog_q     <= '0;
        end else begin
            sw_sync1_q <= sw_sync1_d;
            sw_sync2_q <= sw_sync2_d;
            cmd_q      <= cmd_d;
            prog_q     <= prog_d;
        end
    end

    assign stop_f_t = cmd_q[CMD_STOP];
    assign update   = cmd_q[CMD_UPDATE];
    assign start_f  = cmd_q[CMD_START_F];
    assign start_t  = cmd_q[CMD_START_T];
    assign prog     = prog_q;

endmodule

// File: tb/tb_cmd_conditioner.sv
// Directed bench for cmd_conditioner with DEBOUNCE_CYCLES=4. Stimulus pushes
// the expected pulse (cycle and output vector) into a scoreboard queue; an
// independent monitor pops and compares whenever any output is non-zero.
module tb_cmd_conditioner;
    import cmd_pkg::*;

    localparam int DC  = 4;
    localparam int LAT = DC + 3;   // drive at negedge n -> pulse seen at negedge n+LAT

    localparam logic [6:0] V_STOP = 7'b1000_000;
    localparam logic [6:0] V_SF   = 7'b0010_000;
    localparam logic [6:0] V_ST   = 7'b0001_000;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              btn_start_f = 1'b0;
    logic              btn_start_t = 1'b0;
    logic              btn_update  = 1'b0;
    logic              btn_stop    = 1'b0;
    logic [PROG_W-1:0] sw_prog     = '0;
    logic              start_f, start_t, update, stop_f_t;
    logic [PROG_W-1:0] prog;
    logic [6:0]        out_vec;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    cmd_conditioner #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start_f(btn_start_f),
        .btn_start_t(btn_start_t),
        .btn_update (btn_update),
        .btn_stop   (btn_stop),
        .sw_prog    (sw_prog),
        .start_f    (start_f),
        .start_t    (start_t),
        .update     (update),
        .stop_f_t   (stop_f_t),
        .prog       (prog)
    );

    assign out_vec = {stop_f_t, update, start_f, start_t, prog};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [6:0] v);
        exp_t e;
        e.cyc = cyc + LAT;
        e.vec = v;
        sb.push_back(e);
    endtask

    // Monitor: any non-zero output must match the oldest expected pulse.
    always @(negedge clk) begin
        if (rst && out_vec != 7'd0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0h at cycle %0d expected nothing", out_vec, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_vec", {25'd0, out_vec}, {25'd0, e.vec});
            end
        end
    end

    initial begin
        // Reset state
        #1;
        check("reset_out", {25'd0, out_vec}, 32'd0);
        tick(3);
        rst = 1'b1;
        tick(3);

        // Clean press of start_f
        btn_start_f = 1'b1;
        expect_pulse(V_SF);
        tick(20);
        btn_start_f = 1'b0;
        tick(15);

        // Bounce on stop: 1,0,1,1,0 then hold high
        btn_stop = 1'b1; tick(1);
        btn_stop = 1'b0; tick(1);
        btn_stop = 1'b1; tick(1);
        btn_stop = 1'b1; tick(1);
        btn_stop = 1'b0; tick(1);
        btn_stop = 1'b1;
        expect_pulse(V_STOP);
        tick(20);
        btn_stop = 1'b0;
        tick(15);

        // Update with prog = 011, then 101
        sw_prog = 3'b011;
        tick(10);
        btn_update = 1'b1;
        expect_pulse({4'b0100, 3'b011});
        tick(20);
        btn_update = 1'b0;
        tick(15);

        sw_prog = 3'b101;
        tick(10);
        btn_update = 1'b1;
        expect_pulse({4'b0100, 3'b101});
        tick(20);
        btn_update = 1'b0;
        tick(15);

        // Simultaneous start_t, update, stop: only stop survives, prog stays 0
        sw_prog = 3'b110;
        tick(10);
        btn_start_t = 1'b1;
        btn_update  = 1'b1;
        btn_stop    = 1'b1;
        expect_pulse(V_STOP);
        tick(20);
        btn_start_t = 1'b0;
        btn_update  = 1'b0;
        btn_stop    = 1'b0;
        tick(15);

        // Reset mid-debounce with start_t held
        btn_start_t = 1'b1;
        tick(2);
        rst = 1'b0;
        #1;
        check("rst_mid_out", {25'd0, out_vec}, 32'd0);
        tick(3);
        rst = 1'b1;
        expect_pulse(V_ST);
        tick(20);
        btn_start_t = 1'b0;
        tick(15);

        // Hold, short release (ignored), long release, repress
        btn_start_f = 1'b1;
        expect_pulse(V_SF);
        tick(50);
        btn_start_f = 1'b0;
        tick(3);
        btn_start_f = 1'b1;
        tick(15);
        btn_start_f = 1'b0;
        tick(6);
        btn_start_f = 1'b1;
        expect_pulse(V_SF);
        tick(20);
        btn_start_f = 1'b0;
        tick(15);

        // Drain: every expected pulse must have been seen
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick(1);
        check("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
